enemy_target: RTL
=================

Name: enemy_target

Overview:
- Receiving end of the player-bullet interface: one enemy soldier consumes the bullet position and firing flag each frame and performs hit detection.
- Tracks the enemy's hit points and drives flash, explode and respawn sequencing.
- Walks left and is compensated for screen scroll using the same -5 px rule as the bullet.
- Sits beside the player-bullet block in the top level; outputs feed the sprite renderer and the score counter.

Parameters:
SPAWN_X, 10'd600, X coordinate on spawn/respawn
SPAWN_Y, 10'd400, Y coordinate (constant; enemy does not move vertically)
HALF_W, 10'd8, hitbox half-width in px
HALF_H, 10'd16, hitbox half-height in px
HP_MAX, 3'd3, hit points on spawn (1..7)
FLASH_FRAMES, 8'd4, invulnerable flash duration after a non-lethal hit
EXPLODE_FRAMES, 8'd16, explosion duration
RESPAWN_FRAMES, 8'd60, hidden time before respawn
WALK_STEP, 10'd1, leftward px per frame

Ports:
frame_clk  in  1  frame-rate clock; all state updates on rising edge
Reset  in  1  asynchronous, active-high
BallX  in  10  player bullet X
BallY  in  10  player bullet Y
bfiring  in  1  player bullet in flight
scroll  in  1  screen scrolling this frame
EnemyX  out  10  enemy centre X
EnemyY  out  10  enemy centre Y
alive  out  1  enemy drawable and hittable (ALIVE or FLASH)
flash  out  1  in FLASH state (renderer blinks sprite)
exploding  out  1  in EXPLODE state
hp  out  3  remaining hit points
hit_pulse  out  1  one frame high on every registered hit
kill_pulse  out  1  one frame high on the lethal hit (score increment)

Behaviour:
- Reset state: state=HIDDEN, frame counter=0, EnemyX=SPAWN_X, EnemyY=SPAWN_Y, hp=HP_MAX, all 1-bit outputs 0, counted latch=0. Reset is honoured mid-sequence from any state.
- FSM states: HIDDEN, ALIVE, FLASH, EXPLODE. The frame counter is reloaded on every state entry.
- HIDDEN
  - Counts RESPAWN_FRAMES frames.
  - On expiry -> ALIVE with EnemyX=SPAWN_X and hp=HP_MAX.
  - First HIDDEN after reset also waits the full RESPAWN_FRAMES.
- Hit condition (combinational, registered effect next edge), all of:
  - bfiring=1
  - counted=0
  - state=ALIVE
  - |BallX-EnemyX|<=HALF_W
  - |BallY-EnemyY|<=HALF_H
  - Differences are computed as 11-bit signed values; no 10-bit wrap.
- ALIVE
  - Movement: EnemyX -= WALK_STEP; if scroll=1, EnemyX -= WALK_STEP+5.
  - On hit with hp>1: hp-1, hit_pulse=1, -> FLASH.
  - On hit with hp==1: hp=0, hit_pulse=1, kill_pulse=1, -> EXPLODE.
- FLASH: movement continues; invulnerable; after FLASH_FRAMES -> ALIVE.
- EXPLODE: EnemyX frozen except the scroll shift (-5); after EXPLODE_FRAMES -> HIDDEN.
- Off-screen despawn: in ALIVE or FLASH, if the next EnemyX would fall below HALF_W (including any underflow), -> HIDDEN with no kill_pulse and no hp change. Despawn takes priority over a same-frame hit.
- counted latch (one bullet = at most one hit):
  - Set on a registered hit.
  - Cleared on any frame with bfiring=0.
  - If a hit and bfiring=0 occur in the same frame, no hit is possible (bfiring=0 blocks the hit condition).
- Pulse outputs are registered and high for exactly one frame_clk cycle.

Optional Feature:
ENEMY_CONTACT_EN
- Defined: adds inputs playerX[9:0] and playerY[9:0] and output player_hit.
  - player_hit pulses one frame when alive=1 and the player centre is within HALF_W+8 / HALF_H+16 of the enemy.
  - A contact pulse is followed by a 30-frame rearm lockout.
- Undefined: those ports, that logic and the lockout counter are absent; all other behaviour is identical.

Decomposition:
- Package contra_enemy_pkg holds:
  - the state enum enemy_state_t {HIDDEN, ALIVE, FLASH, EXPLODE}
  - SCREEN_W=640, SCROLL_STEP=5, PARK_Y=485
- One sub-module, box_hit: combinational signed-difference overlap test.
  - Inputs: ax, ay, bx, by, half_w, half_h.
  - Output: overlap.
  - Reused for bullet and contact checks.

Test Plan:
- Reset, then 60 frames -> alive rises on frame 61, EnemyX=600, hp=3.
- Bullet held at (590,400) with bfiring=1 across 10 frames while alive -> exactly one hit_pulse, hp=2, flash=1 for 4 frames, no second hit until bfiring drops.
- Three separate bullets (bfiring toggled 0 between them), each hitting after its flash ends -> hp 3→2→1→0, kill_pulse on the third only, exploding=1 for 16 frames, then HIDDEN for 60 frames, respawn at 600 with hp=3.
- Bullet at EnemyX+9 (outside HALF_W=8) -> no hit; at EnemyX+8 -> hit registered.
- scroll=1 held from spawn -> EnemyX decreases by 6 per frame; despawns to HIDDEN when the next X would be <8; kill_pulse stays 0.
- Reset asserted mid-EXPLODE -> all outputs return to reset values immediately; the next respawn occurs after a full 60 frames.

Source files
------------

// File: rtl/enemy_target_pkg.sv
// ============================================================================
// contra_enemy_pkg : shared enemy state encoding and screen constants
// Rev 1.0
// ============================================================================
`default_nettype none

package contra_enemy_pkg;

    typedef enum logic [1:0] {
        HIDDEN  = 2'd0,
        ALIVE   = 2'd1,
        FLASH   = 2'd2,
        EXPLODE = 2'd3
    } enemy_state_t;

    localparam logic [9:0] SCREEN_W    = 10'd640;
    localparam logic [9:0] SCROLL_STEP = 10'd5;
    localparam logic [9:0] PARK_Y      = 10'd485;

endpackage

`default_nettype wire

// File: rtl/enemy_target_box_hit.sv
// ============================================================================
// box_hit : axis-aligned overlap test on 11-bit signed centre differences
// Rev 1.0
// ============================================================================
`default_nettype none

module box_hit (
    input  logic [9:0] ax,
    input  logic [9:0] ay,
    input  logic [9:0] bx,
    input  logic [9:0] by,
    input  logic [9:0] half_w,
    input  logic [9:0] half_h,
    output logic       overlap
);

    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic        [10:0] w_adx;
    logic        [10:0] w_ady;

    // One extra bit keeps the difference from wrapping across screen edges
    assign w_dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
    assign w_dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
    assign w_adx = w_dx[10] ? $unsigned(-w_dx) : $unsigned(w_dx);
    assign w_ady = w_dy[10] ? $unsigned(-w_dy) : $unsigned(w_dy);

    assign overlap = (w_adx <= {1'b0, half_w}) && (w_ady <= {1'b0, half_h});

endmodule

`default_nettype wire

// File: rtl/enemy_target.sv
// ============================================================================
// enemy_target : enemy soldier hit detection, HP and flash/explode/respawn FSM
// Optional ENEMY_CONTACT_EN adds a player body-contact pulse with lockout.
// Rev 1.0
// ============================================================================
`default_nettype none

module enemy_target
    import contra_enemy_pkg::*;
#(
    parameter logic [9:0] SPAWN_X        = 10'd600,
    parameter logic [9:0] SPAWN_Y        = 10'd400,
    parameter logic [9:0] HALF_W         = 10'd8,
    parameter logic [9:0] HALF_H         = 10'd16,
    parameter logic [2:0] HP_MAX         = 3'd3,
    parameter logic [7:0] FLASH_FRAMES   = 8'd4,
    parameter logic [7:0] EXPLODE_FRAMES = 8'd16,
    parameter logic [7:0] RESPAWN_FRAMES = 8'd60,
    parameter logic [9:0] WALK_STEP      = 10'd1
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic       bfiring,
    input  logic       scroll,
    output logic [9:0] EnemyX,
    output logic [9:0] EnemyY,
    output logic       alive,
    output logic       flash,
    output logic       exploding,
    output logic [2:0] hp,
    output logic       hit_pulse,
    output logic       kill_pulse
`ifdef ENEMY_CONTACT_EN
    ,
    input  logic [9:0] playerX,
    input  logic [9:0] playerY,
    output logic       player_hit
`endif
);

    enemy_state_t r_state;
    logic [7:0]   r_cnt;
    logic         r_counted;

    logic [9:0]   w_step;
    logic [10:0]  w_walk_x;
    logic         w_despawn;
    logic [9:0]   w_scroll_x;
    logic         w_bullet_ovl;
    logic         w_hit;

    assign EnemyY = SPAWN_Y;

    box_hit u_bullet_hit (
        .ax      (BallX),
        .ay      (BallY),
        .bx      (EnemyX),
        .by      (SPAWN_Y),
        .half_w  (HALF_W),
        .half_h  (HALF_H),
        .overlap (w_bullet_ovl)
    );

    assign w_step     = scroll ? (WALK_STEP + SCROLL_STEP) : WALK_STEP;
    assign w_walk_x   = {1'b0, EnemyX} - {1'b0, w_step};
    // Bit 10 set means the walk underflowed past zero
    assign w_despawn  = w_walk_x[10] || (w_walk_x[9:0] < HALF_W);
    assign w_scroll_x = scroll ? (EnemyX - SCROLL_STEP) : EnemyX;
    assign w_hit      = bfiring && !r_counted && (r_state == ALIVE) && w_bullet_ovl && !w_despawn;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= HIDDEN;
            r_cnt      <= 8'd0;
            r_counted  <= 1'b0;
            EnemyX     <= SPAWN_X;
            hp         <= HP_MAX;
            alive      <= 1'b0;
            flash      <= 1'b0;
            exploding  <= 1'b0;
            hit_pulse  <= 1'b0;
            kill_pulse <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            kill_pulse <= 1'b0;

            if (!bfiring)
                r_counted <= 1'b0;
            else if (w_hit)
                r_counted <= 1'b1;

            case (r_state)
                HIDDEN: begin
                    if (r_cnt == RESPAWN_FRAMES - 8'd1) begin
                        r_state <= ALIVE;
                        r_cnt   <= 8'd0;
                        EnemyX  <= SPAWN_X;
                        hp      <= HP_MAX;
                        alive   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ALIVE: begin
                    if (w_despawn) begin
                        r_state <= HIDDEN;
                        r_cnt   <= 8'd0;
                        alive   <= 1'b0;
                    end else begin
                        EnemyX <= w_walk_x[9:0];
                        r_cnt  <= 8'd0;
                        if (w_hit) begin
                            hit_pulse <= 1'b1;
                            if (hp == 3'd1) begin
                                hp         <= 3'd0;
                                kill_pulse <= 1'b1;
                                r_state    <= EXPLODE;
                                alive      <= 1'b0;
                                exploding  <= 1'b1;
                            end else begin
                                hp      <= hp - 3'd1;
                                r_state <= FLASH;
                                flash   <= 1'b1;
                            end
                        end
                    end
                end
                FLASH: begin
                    if (w_despawn) begin
                        r_state <= HIDDEN;
                        r_cnt   <= 8'd0;
                        alive   <= 1'b0;
                        flash   <= 1'b0;
                    end else begin
                        EnemyX <= w_walk_x[9:0];
                        if (r_cnt == FLASH_FRAMES - 8'd1) begin
                            r_state <= ALIVE;
                            r_cnt   <= 8'd0;
                            flash   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                EXPLODE: begin
                    EnemyX <= w_scroll_x;
                    if (r_cnt == EXPLODE_FRAMES - 8'd1) begin
                        r_state   <= HIDDEN;
                        r_cnt     <= 8'd0;
                        exploding <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= HIDDEN;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

`ifdef ENEMY_CONTACT_EN
    logic       w_contact;
    logic [4:0] r_lockout;

    box_hit u_contact_hit (
        .ax      (playerX),
        .ay      (playerY),
        .bx      (EnemyX),
        .by      (SPAWN_Y),
        .half_w  (HALF_W + 10'd8),
        .half_h  (HALF_H + 10'd16),
        .overlap (w_contact)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_lockout  <= 5'd0;
            player_hit <= 1'b0;
        end else begin
            player_hit <= 1'b0;
            if (r_lockout != 5'd0) begin
                r_lockout <= r_lockout - 5'd1;
            end else if (alive && w_contact) begin
                player_hit <= 1'b1;
                r_lockout  <= 5'd30;
            end
        end
    end
`endif

endmodule

`default_nettype wire
